// File: rtl/ecc_scrub_ctrl.sv
// Background ECC scrubber: walks the memory between functional accesses,
// writes back single-bit corrections and keeps error statistics.
module ecc_scrub_ctrl #(
    parameter int DATA_WIDTH   = 185,
    parameter int PARITY_WIDTH = 9,
    parameter int ADDR_WIDTH   = 6
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    scrub_en,
    input  logic [15:0]             scrub_interval,
    input  logic                    err_clr,
    input  logic                    func_req,
    input  logic                    func_wen,
    input  logic [ADDR_WIDTH-1:0]   func_waddr,
    output logic                    mem_ren,
    output logic [ADDR_WIDTH-1:0]   mem_addr,
    input  logic [DATA_WIDTH-1:0]   mem_rdata,
    input  logic [PARITY_WIDTH-1:0] mem_rparity,
    output logic [DATA_WIDTH-1:0]   chk_data,
    output logic [PARITY_WIDTH-1:0] chk_parity,
    input  logic [DATA_WIDTH-1:0]   chk_data_out,
    input  logic                    chk_sbit_err,
    input  logic                    chk_dbit_err,
    input  logic                    chk_fault,
    output logic                    mem_wen,
    output logic [DATA_WIDTH-1:0]   mem_wdata,
    output logic [7:0]              sbit_cnt,
    output logic [7:0]              dbit_cnt,
    output logic                    fault_flag,
    output logic                    dbit_irq,
    output logic                    pass_done,
    output logic                    scrub_busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_READ,
        S_CHECK,
        S_WRITE
    } state_t;

    state_t                  state_q, state_d;
    logic [15:0]             cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic                    phase_q, phase_d;
    logic                    cancel_q, cancel_d;
    logic [DATA_WIDTH-1:0]   cdata_q, cdata_d;
    logic [PARITY_WIDTH-1:0] cpar_q, cpar_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [7:0]              sbit_q, sbit_d;
    logic [7:0]              dbit_q, dbit_d;
    logic                    fault_q, fault_d;
    logic                    irq_q, irq_d;
    logic                    pass_q, pass_d;

    logic collide;
    logic in_window;
    logic adv;
    logic sinc;
    logic dinc;
    logic fset;

    assign in_window = (state_q == S_READ) || (state_q == S_CHECK) ||
                       (state_q == S_WRITE);
    assign collide   = in_window && func_wen && (func_waddr == addr_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            addr_q   <= '0;
            phase_q  <= 1'b0;
            cancel_q <= 1'b0;
            cdata_q  <= '0;
            cpar_q   <= '0;
            wdata_q  <= '0;
            sbit_q   <= '0;
            dbit_q   <= '0;
            fault_q  <= 1'b0;
            irq_q    <= 1'b0;
            pass_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            addr_q   <= addr_d;
            phase_q  <= phase_d;
            cancel_q <= cancel_d;
            cdata_q  <= cdata_d;
            cpar_q   <= cpar_d;
            wdata_q  <= wdata_d;
            sbit_q   <= sbit_d;
            dbit_q   <= dbit_d;
            fault_q  <= fault_d;
            irq_q    <= irq_d;
            pass_q   <= pass_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        addr_d   = addr_q;
        phase_d  = phase_q;
        cancel_d = cancel_q | collide;
        cdata_d  = cdata_q;
        cpar_d   = cpar_q;
        wdata_d  = wdata_q;
        irq_d    = 1'b0;
        pass_d   = 1'b0;
        adv      = 1'b0;
        sinc     = 1'b0;
        dinc     = 1'b0;
        fset     = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                cancel_d = 1'b0;
                if (scrub_en) begin
                    cnt_d   = scrub_interval;
                    addr_d  = '0;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                cancel_d = 1'b0;
                if (cnt_q <= 16'd1) begin
                    cnt_d   = '0;
                    state_d = S_READ;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            S_READ: begin
                if (mem_ren) begin
                    phase_d = 1'b0;
                    state_d = S_CHECK;
                end
            end
            S_CHECK: begin
                if (!phase_q) begin
                    cdata_d = mem_rdata;
                    cpar_d  = mem_rparity;
                    phase_d = 1'b1;
                end else begin
                    phase_d = 1'b0;
                    fset    = chk_fault;
                    dinc    = chk_dbit_err;
                    irq_d   = chk_dbit_err;
                    if (chk_sbit_err && !chk_dbit_err && !chk_fault) begin
                        sinc    = 1'b1;
                        wdata_d = chk_data_out;
                        if (cancel_q || collide) begin
                            adv = 1'b1;
                        end else begin
                            state_d = S_WRITE;
                        end
                    end else begin
                        adv = 1'b1;
                    end
                end
            end
            S_WRITE: begin
                // a functional write to this word makes our correction stale
                if (cancel_q || collide || mem_wen) begin
                    adv = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        if (adv) begin
            cancel_d = 1'b0;
            if (addr_q == '1) begin
                addr_d  = '0;
                pass_d  = 1'b1;
                cnt_d   = scrub_interval;
                state_d = S_WAIT;
            end else begin
                addr_d  = addr_q + ADDR_WIDTH'(1);
                state_d = S_READ;
            end
        end
        if (!scrub_en) begin
            state_d  = S_IDLE;
            phase_d  = 1'b0;
            cancel_d = 1'b0;
            pass_d   = 1'b0;
        end
        sbit_d  = sbit_q;
        dbit_d  = dbit_q;
        fault_d = fault_q | fset;
        if (sinc && sbit_q != 8'hFF) begin
            sbit_d = sbit_q + 8'd1;
        end
        if (dinc && dbit_q != 8'hFF) begin
            dbit_d = dbit_q + 8'd1;
        end
        if (err_clr) begin
            sbit_d  = '0;
            dbit_d  = '0;
            fault_d = 1'b0;
        end
    end

    always_comb begin
        mem_ren    = 1'b0;
        mem_wen    = 1'b0;
        scrub_busy = in_window;
        if (scrub_en && !func_req) begin
            mem_ren = (state_q == S_READ);
            mem_wen = (state_q == S_WRITE) && !cancel_q && !collide;
        end
    end

    assign mem_addr   = addr_q;
    assign chk_data   = cdata_q;
    assign chk_parity = cpar_q;
    assign mem_wdata  = wdata_q;
    assign sbit_cnt   = sbit_q;
    assign dbit_cnt   = dbit_q;
    assign fault_flag = fault_q;
    assign dbit_irq   = irq_q;
    assign pass_done  = pass_q;

endmodule

// File: doc/ecc_scrub_ctrl.md
ECC_SCRUB_CTRL -- requirements
Module: ecc_scrub_ctrl

Interface
REQ-001 Parameter DATA_WIDTH, default 185, protected data word width.
REQ-002 Parameter PARITY_WIDTH, default 9, ECC parity width.
REQ-003 Parameter ADDR_WIDTH, default 6, memory address width; memory depth is 2^ADDR_WIDTH.
REQ-004 Port clk  input  1  clock; all logic SHALL be on the rising edge.
REQ-005 Port rst_n  input  1  asynchronous active-low reset.
REQ-006 Port scrub_en  input  1  enables scrubbing.
REQ-007 Port scrub_interval  input  16  idle cycles between scrub passes.
REQ-008 Port err_clr  input  1  single-cycle pulse that clears the counters and the sticky flag.
REQ-009 Port func_req  input  1  functional access owns the memory port this cycle.
REQ-010 Port func_wen  input  1  functional write this cycle.
REQ-011 Port func_waddr  input  ADDR_WIDTH  functional write address.
REQ-012 Port mem_ren  output  1  scrub read strobe; read data returns 1 cycle later.
REQ-013 Port mem_addr  output  ADDR_WIDTH  scrub read/write address.
REQ-014 Port mem_rdata  input  DATA_WIDTH  read data.
REQ-015 Port mem_rparity  input  PARITY_WIDTH  read parity.
REQ-016 Port chk_data  output  DATA_WIDTH  data to the ECC checker (registered mem_rdata).
REQ-017 Port chk_parity  output  PARITY_WIDTH  parity to the ECC checker.
REQ-018 Port chk_data_out  input  DATA_WIDTH  corrected data from the checker.
REQ-019 Port chk_sbit_err, chk_dbit_err, chk_fault  input  1 each  checker status, combinational from chk_data/chk_parity.
REQ-020 Port mem_wen  output  1  scrub writeback strobe.
REQ-021 Port mem_wdata  output  DATA_WIDTH  registered corrected data; parity is regenerated externally.
REQ-022 Ports sbit_cnt, dbit_cnt  output  8 each  saturating error counters.
REQ-023 Port fault_flag  output  1  sticky checker-fault flag.
REQ-024 Port dbit_irq  output  1  one-cycle pulse on an uncorrectable error.
REQ-025 Port pass_done  output  1  one-cycle pulse at the end of a full pass.
REQ-026 Port scrub_busy  output  1  high in any state except IDLE and WAIT.

Function
REQ-027 FSM states SHALL be IDLE, WAIT, READ, CHECK, WRITE.
REQ-028 IDLE: when scrub_en=1, load the interval counter with scrub_interval, clear the address to 0, and go to WAIT.
REQ-029 WAIT: decrement the counter each cycle; at 0, go to READ.
- scrub_interval=0 SHALL go to READ on the next cycle.
REQ-030 READ: assert mem_ren only when func_req=0, then go to CHECK; otherwise stall in READ with mem_ren=0.
REQ-031 CHECK (read data valid this cycle): register mem_rdata/mem_rparity onto chk_data/chk_parity; the next cycle (CHECK, second phase) evaluate checker status. CHECK SHALL last exactly 2 cycles.
REQ-032 In CHECK phase 2, on chk_sbit_err=1 with chk_dbit_err=0 and chk_fault=0:
- latch chk_data_out into mem_wdata;
- increment sbit_cnt;
- go to WRITE.
Otherwise advance the address and go to READ.
REQ-033 On chk_dbit_err=1: increment dbit_cnt, pulse dbit_irq, skip writeback.
REQ-034 On chk_fault=1: set fault_flag and skip writeback; a simultaneous sbit_err SHALL NOT count.
REQ-035 WRITE: assert mem_wen for one cycle when func_req=0, then advance the address; stall while func_req=1.
REQ-036 Collision: func_wen=1 with func_waddr==mem_addr at any cycle from READ issue through WRITE SHALL cancel the pending writeback (mem_wen never asserted for that address). The sbit count still SHALL stand.
REQ-037 Address wrap: advancing from 2^ADDR_WIDTH-1 SHALL set the address to 0, pulse pass_done, reload the interval counter, and go to WAIT.
REQ-038 Counters SHALL saturate at 255. err_clr SHALL clear sbit_cnt, dbit_cnt and fault_flag; err_clr coincident with an increment SHALL yield 0.
REQ-039 scrub_en=0 in any state SHALL return the FSM to IDLE on the next edge, aborting any pending read or writeback; counters SHALL be retained.
REQ-040 mem_ren and mem_wen SHALL never be high while func_req=1, and SHALL never be high together.

Reset
REQ-041 On rst_n=0 the FSM SHALL be IDLE, and all outputs (mem_ren, mem_wen, mem_addr, mem_wdata, chk_data, chk_parity, counters, fault_flag, dbit_irq, pass_done, scrub_busy) SHALL be 0.
REQ-042 Reset asserted mid-operation SHALL abort immediately with no mem_wen pulse; scrubbing SHALL restart at address 0 after release.

Verification
REQ-043 ADDR_WIDTH=2, interval=3, clean memory -> one mem_ren per address 0..3, pass_done pulse after address 3, 3 WAIT cycles, then a repeat.
REQ-044 Single-bit error at address 2 -> exactly one mem_wen at addr 2 with corrected data, sbit_cnt=1.
REQ-045 Double-bit error at address 1 -> dbit_irq pulses once, dbit_cnt=1, no mem_wen.
REQ-046 func_req held high 5 cycles during READ/WRITE -> mem_ren/mem_wen delayed 5 cycles; func_wen to the same address before WRITE -> no mem_wen.
REQ-047 300 single-bit errors -> sbit_cnt=255; err_clr -> 0; chk_fault=1 -> fault_flag=1 until err_clr.
REQ-048 rst_n low during WRITE stall -> all outputs 0, no mem_wen; after release the next read is at address 0.
